// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
//   XLEN          : architectural register / address width
//   INSTR_NOP     : ADDI x0,x0,0, presented to decode whenever no instruction is valid
//   fetch_state_e : fetch controller states
//   fetch_entry_t : one prefetch buffer entry (instruction word + its PC)
//   word_align    : clears the two low address bits
package riscv_fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched instruction words with their PCs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full and not popping)
//   i_data     : entry to write
//   i_pop      : remove head (ignored when empty)
//   i_clear    : drop all entries; wins over push/pop
//   o_head     : head entry, read combinationally from registered storage
//   o_count    : number of stored entries
//   o_empty    : no entry stored
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == {CW{1'b0}});
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {$bits(fetch_entry_t){1'b0}};
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: keeps the PC, issues in-order word requests
// over a valid/ready link, buffers responses with their PCs and feeds decode.
// A redirect flushes buffered entries and discards in-flight responses.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_rsp_valid/data              : in-order response channel
//   redirect_valid/redirect_pc       : taken branch/jump from execute
//   dec_ready                        : decode consumes out_* this cycle
//   out_valid/out_instr/out_pc       : instruction presented to decode
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetched : instructions popped to decode
//   perf_flushed : FIFO entries plus responses discarded by redirects
module fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_inflight_nxt;
  logic [CW-1:0]   w_discard_nxt;

  logic            w_req_valid;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_rsp_pc;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;

  assign w_accept = w_req_valid && imem_req_ready;

  // Outstanding requests after this cycle's accept and response.
  assign w_inflight_nxt = r_inflight + {{(CW-1){1'b0}}, w_accept}
                                     - {{(CW-1){1'b0}}, imem_rsp_valid};

  // Responses still to drop: reloaded from the outstanding count on redirect.
  always_comb begin
    w_discard_nxt = r_discard;
    if (redirect_valid) begin
      w_discard_nxt = w_inflight_nxt;
    end else if (r_state == FLUSH && imem_rsp_valid) begin
      w_discard_nxt = r_discard - CW'(1'b1);
    end else begin
      w_discard_nxt = r_discard;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT: w_state_nxt = FETCH;
      FETCH: begin
        if (redirect_valid && (w_inflight_nxt != {CW{1'b0}})) w_state_nxt = FLUSH;
        else                                                   w_state_nxt = FETCH;
      end
      FLUSH: begin
        if (redirect_valid) begin
          w_state_nxt = (w_inflight_nxt != {CW{1'b0}}) ? FLUSH : FETCH;
        end else if (w_discard_nxt == {CW{1'b0}}) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  // FSM outputs: request only while outstanding + buffered leaves a free FIFO slot.
  // That sum never grows without an accept, so a raised request is held stable.
  always_comb begin
    w_req_valid = 1'b0;
    case (r_state)
      FETCH:   w_req_valid = (({1'b0, r_inflight} + {1'b0, w_fifo_count}) < {1'b0, DEPTH_C});
      default: w_req_valid = 1'b0;
    endcase
  end

  // PC, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= {CW{1'b0}};
      r_discard  <= {CW{1'b0}};
    end else begin
      if (redirect_valid)  r_pc <= word_align(redirect_pc);
      else if (w_accept)   r_pc <= r_pc + 32'd4;
      r_inflight <= w_inflight_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  // In FETCH every outstanding request is live, so the oldest one was issued
  // at r_pc minus four bytes per outstanding request.
  assign w_rsp_pc           = r_pc - 32'({r_inflight, 2'b00});
  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = w_rsp_pc;

  // Redirect wins over a same-cycle response push and decode pop.
  assign w_push = imem_rsp_valid && (r_state == FETCH) && !redirect_valid;
  assign w_pop  = !w_fifo_empty && dec_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign out_valid      = !w_fifo_empty;
  assign out_instr      = w_fifo_empty ? INSTR_NOP : w_head.instr;
  assign out_pc         = w_fifo_empty ? r_pc      : w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [31:0] w_flush_inc;

  // Discards: whole FIFO on redirect, plus any response dropped this cycle.
  assign w_flush_inc = (redirect_valid ? 32'(w_fifo_count) : 32'd0)
                     + ((imem_rsp_valid && ((r_state != FETCH) || redirect_valid)) ? 32'd1 : 32'd0);

  // Performance counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'd0;
      r_perf_flushed <= 32'd0;
    end else begin
      r_perf_fetched <= r_perf_fetched + (w_pop ? 32'd1 : 32'd0);
      r_perf_flushed <= r_perf_flushed + w_flush_inc;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule
